shrimp_muldiv_seq: RTL and testbench

- Multi-cycle sequencer that drives the shared 8-bit ALU to perform 8x8 unsigned multiply (16-bit product) and 8/8 unsigned divide (quotient plus remainder).
- Sits beside the ALU in the execute stage; while busy it owns the ALU operand/opcode inputs via a core-side mux selected by alu_busy.
- Shifting and carry derivation are done locally. The ALU supplies the adds and the divisor negation.

---
 rtl/shrimp_alu_defs_pkg.sv | 29 ++
 rtl/shrimp_alu.sv | 27 ++
 rtl/shrimp_muldiv_seq.sv | 149 ++++++++++++++
 tb/tb_shrimp_muldiv_seq.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shrimp_alu_defs_pkg.sv
// Shared type definitions for the 8-bit execute-stage ALU and the
// multiply/divide sequencer that borrows it.
package shrimp_alu_defs;

    typedef enum logic [2:0] {
        ADDU  = 3'd0,
        SUBU  = 3'd1,
        ANDB  = 3'd2,
        ORB   = 3'd3,
        XORB  = 3'd4,
        NEG   = 3'd5,
        PASSA = 3'd6,
        PASSB = 3'd7
    } alu_opcode_e;

    typedef enum logic {
        MULU = 1'b0,
        DIVU = 1'b1
    } seq_op_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREP     = 3'd1,
        S_MUL_ITER = 3'd2,
        S_DIV_ITER = 3'd3,
        S_DONE     = 3'd4
    } seq_state_e;

endpackage

// File: rtl/shrimp_alu.sv
// Shared combinational 8-bit ALU of the execute stage.
// Carry is not exported; consumers derive it from the result when needed.
module shrimp_alu
    import shrimp_alu_defs::*;
(
    input  alu_opcode_e  op,
    input  logic [7:0]   operand_a,
    input  logic [7:0]   operand_b,
    output logic [7:0]   result
);

    always_comb begin
        result = 8'h00;
        case (op)
            ADDU:    result = operand_a + operand_b;
            SUBU:    result = operand_a - operand_b;
            ANDB:    result = operand_a & operand_b;
            ORB:     result = operand_a | operand_b;
            XORB:    result = operand_a ^ operand_b;
            NEG:     result = 8'h00 - operand_a;
            PASSA:   result = operand_a;
            PASSB:   result = operand_b;
            default: result = operand_a + operand_b;
        endcase
    end

endmodule

// File: rtl/shrimp_muldiv_seq.sv
// Multi-cycle 8x8 unsigned multiply / 8/8 unsigned divide sequencer that
// borrows the shared ALU for its adds and the one-time divisor negation.
//
// state      | meaning
// S_IDLE     | waiting for a request, start_ready high
// S_PREP     | ALU negates the divisor once, latched into negdiv
// S_MUL_ITER | one shift-add step per cycle, ITERS cycles
// S_DIV_ITER | one restoring-divide step per cycle, ITERS cycles
// S_DONE     | result presented until res_ready
module shrimp_muldiv_seq
    import shrimp_alu_defs::*;
#(
    parameter int          ITERS     = 8,
    parameter logic [7:0]  DIV0_QUOT = 8'hFF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  seq_op_e      start_op,
    input  logic [7:0]   start_a,
    input  logic [7:0]   start_b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [7:0]   res_hi,
    output logic [7:0]   res_lo,
    output logic         res_div0,
    output logic         alu_busy,
    output logic [7:0]   alu_a,
    output logic [7:0]   alu_b,
    output alu_opcode_e  alu_op,
    input  logic [7:0]   alu_result
);

    localparam logic [2:0] CNT_LOAD = 3'(ITERS - 1);

    // acc holds the product high byte (MULU) or the remainder (DIVU);
    // shf holds the low byte / quotient and shifts one bit per step.
    seq_state_e  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  acc_q, acc_d;
    logic [7:0]  shf_q, shf_d;
    logic [7:0]  opb_q, opb_d;
    logic [7:0]  negdiv_q, negdiv_d;
    logic        div0_q, div0_d;

    logic [8:0]  div_s9;
    logic [7:0]  div_sl;
    logic        mul_c;
    logic        div_ge;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        shf_d    = shf_q;
        opb_d    = opb_q;
        negdiv_d = negdiv_q;
        div0_d   = div0_q;
        alu_a    = 8'h00;
        alu_b    = 8'h00;
        alu_op   = ADDU;
        div_s9   = {acc_q, shf_q[7]};
        div_sl   = div_s9[7:0];
        mul_c    = 1'b0;
        div_ge   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    div0_d = 1'b0;
                    acc_d  = 8'h00;
                    shf_d  = start_a;
                    opb_d  = start_b;
                    cnt_d  = CNT_LOAD;
                    if (start_op == MULU) begin
                        state_d = S_MUL_ITER;
                    end else if (start_b == 8'h00) begin
                        acc_d   = start_a;
                        shf_d   = DIV0_QUOT;
                        div0_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_PREP;
                    end
                end
            end
            S_PREP: begin
                alu_op   = NEG;
                alu_a    = opb_q;
                negdiv_d = alu_result;
                cnt_d    = CNT_LOAD;
                state_d  = S_DIV_ITER;
            end
            S_MUL_ITER: begin
                alu_a = acc_q;
                alu_b = shf_q[0] ? opb_q : 8'h00;
                // a wrapped 8-bit sum is smaller than either addend
                mul_c = (alu_result < acc_q);
                {acc_d, shf_d} = {mul_c, alu_result, shf_q[7:1]};
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd0) state_d = S_DONE;
            end
            S_DIV_ITER: begin
                alu_a  = div_sl;
                alu_b  = negdiv_q;
                // sl + (-div) carries out exactly when sl >= div
                div_ge = div_s9[8] | (alu_result < div_sl);
                acc_d  = div_ge ? alu_result : div_sl;
                shf_d  = {shf_q[6:0], div_ge};
                cnt_d  = cnt_q - 3'd1;
                if (cnt_q == 3'd0) state_d = S_DONE;
            end
            S_DONE: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            acc_q    <= 8'h00;
            shf_q    <= 8'h00;
            opb_q    <= 8'h00;
            negdiv_q <= 8'h00;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            shf_q    <= shf_d;
            opb_q    <= opb_d;
            negdiv_q <= negdiv_d;
            div0_q   <= div0_d;
        end
    end

    assign start_ready = (state_q == S_IDLE);
    assign res_valid   = (state_q == S_DONE);
    assign alu_busy    = (state_q == S_PREP) || (state_q == S_MUL_ITER) ||
                         (state_q == S_DIV_ITER);
    assign res_hi      = acc_q;
    assign res_lo      = shf_q;
    assign res_div0    = div0_q;

endmodule

// File: tb/tb_shrimp_muldiv_seq.sv
// Randomised self-checking bench for shrimp_muldiv_seq driving the shared ALU,
// compared against plain integer multiply/divide.
module tb_shrimp_muldiv_seq;
    import shrimp_alu_defs::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic         start_ready;
    seq_op_e      start_op = MULU;
    logic [7:0]   start_a = 8'h00;
    logic [7:0]   start_b = 8'h00;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [7:0]   res_hi;
    logic [7:0]   res_lo;
    logic         res_div0;
    logic         alu_busy;
    logic [7:0]   alu_a;
    logic [7:0]   alu_b;
    alu_opcode_e  alu_op;
    logic [7:0]   alu_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shrimp_muldiv_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_op    (start_op),
        .start_a     (start_a),
        .start_b     (start_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .res_div0    (res_div0),
        .alu_busy    (alu_busy),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result)
    );

    shrimp_alu alu (
        .op        (alu_op),
        .operand_a (alu_a),
        .operand_b (alu_b),
        .result    (alu_result)
    );

    // Reference: plain integer arithmetic
    task automatic ref_model(input seq_op_e op, input logic [7:0] a, input logic [7:0] b,
                             output logic [7:0] hi, output logic [7:0] lo,
                             output logic d0, output int lat, output int busy);
        int p;
        if (op == MULU) begin
            p = int'(a) * int'(b);
            hi = 8'(p / 256); lo = 8'(p % 256); d0 = 1'b0; lat = 9; busy = 8;
        end else if (b == 8'h00) begin
            hi = a; lo = 8'hFF; d0 = 1'b1; lat = 1; busy = 0;
        end else begin
            hi = 8'(int'(a) % int'(b)); lo = 8'(int'(a) / int'(b)); d0 = 1'b0;
            lat = 10; busy = 9;
        end
    endtask

    // Issues one request, observes it to completion, holds res_ready low for
    // 'hold' cycles (offering a competing request meanwhile), then acknowledges.
    task automatic run_op(input seq_op_e op, input logic [7:0] a, input logic [7:0] b,
                          input int hold,
                          output int lat, output int busy_n, output int busy_first,
                          output int busy_last, output int alu_viol, output int unstable,
                          output int ready_viol, output logic [7:0] hi,
                          output logic [7:0] lo, output logic d0);
        lat = -1; busy_n = 0; busy_first = -1; busy_last = -1;
        alu_viol = 0; unstable = 0; ready_viol = 0;
        hi = 8'h00; lo = 8'h00; d0 = 1'b0;
        @(negedge clk);
        start_valid = 1'b1; start_op = op; start_a = a; start_b = b; res_ready = 1'b0;
        @(posedge clk);
        #1;
        start_valid = 1'b0; start_a = 8'($urandom); start_b = 8'($urandom);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (alu_busy) begin
                busy_n++;
                if (busy_first < 0) busy_first = cyc;
                busy_last = cyc;
            end else if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_op !== ADDU) begin
                alu_viol++;
            end
            if (res_valid) begin
                lat = cyc;
                break;
            end
        end
        if (lat >= 0) begin
            hi = res_hi; lo = res_lo; d0 = res_div0;
            for (int i = 0; i < hold; i++) begin
                start_valid = 1'b1; start_op = MULU; start_a = 8'h11; start_b = 8'h22;
                @(negedge clk);
                if (!res_valid || res_hi !== hi || res_lo !== lo || res_div0 !== d0)
                    unstable++;
                if (start_ready !== 1'b0) ready_viol++;
            end
            start_valid = 1'b0;
            res_ready = 1'b1;
            @(posedge clk);
            #1;
            res_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0 || res_hi !== 8'h00 ||
            res_lo !== 8'h00 || res_div0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake got ready=%b valid=%b hi=%h lo=%h d0=%b expected 1 0 00 00 0",
                     start_ready, res_valid, res_hi, res_lo, res_div0);
        end
        checks++;
        if (alu_busy !== 1'b0 || alu_a !== 8'h00 || alu_b !== 8'h00 || alu_op !== ADDU) begin
            errors++;
            $display("FAIL reset_alu got busy=%b a=%h b=%h op=%0d expected 0 00 00 %0d",
                     alu_busy, alu_a, alu_b, alu_op, ADDU);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_op(input string tag, input seq_op_e op,
                            input logic [7:0] a, input logic [7:0] b, input int hold);
        int lat, bn, bf, bl, av, us, rv, elat, ebusy;
        logic [7:0] hi, lo, ehi, elo;
        logic d0, ed0;
        ref_model(op, a, b, ehi, elo, ed0, elat, ebusy);
        run_op(op, a, b, hold, lat, bn, bf, bl, av, us, rv, hi, lo, d0);
        checks++;
        if (lat !== elat) begin
            errors++;
            $display("FAIL %s_latency op=%0d a=%h b=%h got %0d expected %0d",
                     tag, op, a, b, lat, elat);
        end
        checks++;
        if (hi !== ehi || lo !== elo || d0 !== ed0) begin
            errors++;
            $display("FAIL %s_result op=%0d a=%h b=%h got hi=%h lo=%h d0=%b expected hi=%h lo=%h d0=%b",
                     tag, op, a, b, hi, lo, d0, ehi, elo, ed0);
        end
        checks++;
        if (bn !== ebusy || (ebusy > 0 && (bf !== 1 || bl !== ebusy))) begin
            errors++;
            $display("FAIL %s_busy op=%0d a=%h b=%h got n=%0d first=%0d last=%0d expected n=%0d cycles 1..%0d",
                     tag, op, a, b, bn, bf, bl, ebusy, ebusy);
        end
        checks++;
        if (av !== 0) begin
            errors++;
            $display("FAIL %s_alu_idle op=%0d a=%h b=%h got %0d driven idle cycles expected 0",
                     tag, op, a, b, av);
        end
        if (hold > 0) begin
            checks++;
            if (us !== 0 || rv !== 0) begin
                errors++;
                $display("FAIL %s_hold got unstable=%0d ready_high=%0d expected 0 0", tag, us, rv);
            end
        end
        checks++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_return_idle got ready=%b valid=%b expected 1 0",
                     tag, start_ready, res_valid);
        end
    endtask

    task automatic test_mulu();
        check_op("mulu", MULU, 8'd13, 8'd11, 0);
        check_op("mulu", MULU, 8'hFF, 8'hFF, 0);
        check_op("mulu", MULU, 8'h00, 8'h80, 0);
        for (int i = 0; i < 10; i++)
            check_op("mulu_rand", MULU, 8'($urandom), 8'($urandom), 0);
    endtask

    task automatic test_divu();
        check_op("divu", DIVU, 8'd200, 8'd7, 0);
        check_op("divu", DIVU, 8'hFF, 8'd1, 0);
        check_op("divu", DIVU, 8'd5, 8'd9, 0);
        check_op("divu", DIVU, 8'hFF, 8'hFF, 0);
        for (int i = 0; i < 10; i++)
            check_op("divu_rand", DIVU, 8'($urandom), 8'($urandom_range(1, 255)), 0);
    endtask

    task automatic test_div0();
        check_op("div0", DIVU, 8'h42, 8'h00, 0);
        for (int i = 0; i < 3; i++)
            check_op("div0_rand", DIVU, 8'($urandom), 8'h00, 0);
    endtask

    task automatic test_backpressure();
        check_op("bp_mulu", MULU, 8'($urandom), 8'($urandom), 5);
        check_op("bp_next", DIVU, 8'($urandom), 8'($urandom_range(1, 255)), 0);
        check_op("bp_div0", DIVU, 8'h9A, 8'h00, 5);
        check_op("bp_after", MULU, 8'h37, 8'h5C, 0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start_valid = 1'b1; start_op = MULU; start_a = 8'h9D; start_b = 8'h37;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0 || res_hi !== 8'h00 ||
            res_lo !== 8'h00 || res_div0 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_handshake got ready=%b valid=%b hi=%h lo=%h d0=%b expected 1 0 00 00 0",
                     start_ready, res_valid, res_hi, res_lo, res_div0);
        end
        checks++;
        if (alu_busy !== 1'b0 || alu_a !== 8'h00 || alu_b !== 8'h00 || alu_op !== ADDU) begin
            errors++;
            $display("FAIL rstmid_alu got busy=%b a=%h b=%h op=%0d expected 0 00 00 %0d",
                     alu_busy, alu_a, alu_b, alu_op, ADDU);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_no_result cycle %0d got valid=%b expected 0", i, res_valid);
            end
        end
        check_op("rstmid_next", MULU, 8'($urandom), 8'($urandom), 0);
    endtask

    task automatic test_back_to_back();
        seq_op_e op;
        logic [7:0] b;
        for (int i = 0; i < 12; i++) begin
            op = seq_op_e'($urandom_range(0, 1));
            b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            check_op("b2b", op, 8'($urandom), b, int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_mulu();
        test_divu();
        test_div0();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
